// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
//   Bundles the keypad pins and the decoded-key outputs of keypad_scanner.
//   master: the scanner side (drives columns and key outputs, senses rows).
//   slave : the board/system side (drives rows, observes everything else).
// Signals:
//   col_n     [3:0] column drive, active-low, one-hot-low
//   row_n     [3:0] row sense, active-low, asynchronous to clk
//   key_code  [3:0] code of the last accepted key
//   key_valid       one-cycle strobe per accepted key
//   key_held        high while the accepted key stays pressed
interface keypad_scanner_if;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    output col_n,
    input  row_n,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    input  col_n,
    output row_n,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 hex keypad one column per slot, builds a 16-bit image of
//   pressed keys per full scan, debounces the per-scan classification
//   (none / single key / multiple keys) and reports accepted keys.
// Parameters:
//   SCAN_DIV       clock cycles per column slot (>= 4)
//   DEBOUNCE_SCANS identical consecutive scans needed to accept (>= 1)
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   kp   keypad_scanner_if.master: col_n out, row_n in, key_code/
//        key_valid/key_held out
module keypad_scanner #(
  parameter int SCAN_DIV       = 25000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master kp
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int DB_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_STABLE = DB_W'(DEBOUNCE_SCANS);

  // Key code for each image bit, indexed by col*4+row.
  localparam logic [3:0] KEY_MAP [16] = '{
    4'h1, 4'h4, 4'h7, 4'hE,   // column 0, rows 0..3
    4'h2, 4'h5, 4'h8, 4'h0,   // column 1
    4'h3, 4'h6, 4'h9, 4'hF,   // column 2
    4'hA, 4'hB, 4'hC, 4'hD    // column 3
  };

  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_kind_e;

  // code is forced to 0 unless kind is CLS_SINGLE, so a plain struct
  // equality compares classifications correctly.
  typedef struct packed {
    cls_kind_e  kind;
    logic [3:0] code;
  } cls_t;

  typedef enum logic {IDLE, PRESSED} state_e;

  // ---------------------------------------------------------------------
  // Row synchronizer (resets to "released")
  // ---------------------------------------------------------------------
  logic [3:0] row_meta, row_sync;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= kp.row_n;
      row_sync <= row_meta;
    end
  end

  // ---------------------------------------------------------------------
  // Column scan
  // ---------------------------------------------------------------------
  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        col_idx;
  logic              sample;
  logic              scan_end;

  // Rows are sampled on the last cycle of a slot so the column has settled
  // and the synchronizer has caught up.
  assign sample   = (slot_cnt == SLOT_LAST);
  assign scan_end = sample && (col_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      col_idx  <= 2'd0;
    end else if (sample) begin
      slot_cnt <= '0;
      col_idx  <= col_idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  assign kp.col_n = ~(4'b0001 << col_idx);

  // ---------------------------------------------------------------------
  // Scan image and classification
  // ---------------------------------------------------------------------
  logic [15:0] image_q, image_next;
  logic [4:0]  bits_set;
  logic [3:0]  last_idx;
  cls_t        cls_now;

  // NOTE: every combinational output gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    image_next = image_q;
    if (sample) begin
      image_next[{col_idx, 2'b00} +: 4] = ~row_sync;
    end
  end

  // Classification uses image_next so the column-3 sample taken this cycle
  // is already part of the image being judged.
  always_comb begin
    bits_set = '0;
    last_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (image_next[i]) begin
        bits_set = bits_set + 5'd1;
        last_idx = 4'(i);
      end
    end
    cls_now.kind = CLS_NONE;
    cls_now.code = 4'h0;
    if (bits_set == 5'd1) begin
      cls_now.kind = CLS_SINGLE;
      cls_now.code = KEY_MAP[last_idx];
    end else if (bits_set != 5'd0) begin
      cls_now.kind = CLS_MULTI;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      image_q <= '0;
    end else begin
      image_q <= image_next;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------
  cls_t            prev_cls;
  logic [DB_W-1:0] db_cnt, db_next;
  logic            stable;

  always_comb begin
    db_next = db_cnt;
    if (cls_now.kind == CLS_MULTI) begin
      db_next = '0;
    end else if (cls_now == prev_cls) begin
      db_next = (db_cnt == DB_STABLE) ? db_cnt : db_cnt + DB_W'(1);
    end else begin
      db_next = DB_W'(1);
    end
  end

  // A multi-key image can never be accepted.
  assign stable = scan_end && (cls_now.kind != CLS_MULTI) && (db_next == DB_STABLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt   <= '0;
      prev_cls <= '{kind: CLS_NONE, code: 4'h0};
    end else if (scan_end) begin
      db_cnt   <= db_next;
      prev_cls <= cls_now;
    end
  end

  // ---------------------------------------------------------------------
  // Press / release state machine
  // ---------------------------------------------------------------------
  state_e     state_q, state_next;
  logic [3:0] key_code_q, key_code_next;
  logic       key_valid_q, key_valid_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_next;
      key_code_q  <= key_code_next;
      key_valid_q <= key_valid_next;
    end
  end

  // stable stays true on every scan once the counter saturates; only a
  // change of key produces a new strobe, so holding a key never retriggers.
  always_comb begin
    state_next     = state_q;
    key_code_next  = key_code_q;
    key_valid_next = 1'b0;
    if (stable) begin
      unique case (state_q)
        IDLE: begin
          if (cls_now.kind == CLS_SINGLE) begin
            state_next     = PRESSED;
            key_code_next  = cls_now.code;
            key_valid_next = 1'b1;
          end
        end
        PRESSED: begin
          if (cls_now.kind == CLS_SINGLE && cls_now.code != key_code_q) begin
            key_code_next  = cls_now.code;
            key_valid_next = 1'b1;
          end else if (cls_now.kind == CLS_NONE) begin
            state_next = IDLE;
          end
        end
      endcase
    end
  end

  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = (state_q == PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Drives a matrix keypad model into keypad_scanner. A reference model,
//   reasoning per scan over the set of pressed keys, predicts accepted keys
//   into a queue; a monitor compares DUT strobes and levels against it.
module tb_keypad_scanner;
  localparam int SD   = 8;
  localparam int DB   = 3;
  localparam int SCAN = 4 * SD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if bus ();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (bus)
  );

  // pressed[r*4+c] = key at row r, column c is down
  logic [15:0] pressed = '0;

  // Keypad matrix: a pressed key connects its row to its column line.
  always_comb begin
    bus.row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c]) bus.row_n[r] = bus.row_n[r] & bus.col_n[c];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] key_of(input int r, input int c);
    logic [3:0] k;
    k = 4'h0;
    case (r)
      0: case (c) 0: k = 4'h1; 1: k = 4'h2; 2: k = 4'h3; default: k = 4'hA; endcase
      1: case (c) 0: k = 4'h4; 1: k = 4'h5; 2: k = 4'h6; default: k = 4'hB; endcase
      2: case (c) 0: k = 4'h7; 1: k = 4'h8; 2: k = 4'h9; default: k = 4'hC; endcase
      default: case (c) 0: k = 4'hE; 1: k = 4'h0; 2: k = 4'hF; default: k = 4'hD; endcase
    endcase
    return k;
  endfunction

  function automatic logic [15:0] kbit(input int r, input int c);
    return 16'(1) << (r * 4 + c);
  endfunction

  // ---------------------------------------------------------------------
  // Reference model: t counts clock edges since reset release.
  // ---------------------------------------------------------------------
  int          t = 0;
  logic [15:0] hist1 = '0, hist2 = '0;  // pressed set 1 and 2 edges ago
  logic [15:0] img = '0;
  int          cls_hist[$];             // 0..15 single key, 16 none, 17 multi
  logic        ref_held = 1'b0;
  logic [3:0]  ref_code = 4'h0;
  logic [3:0]  exp_q[$];

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        t = 0; hist1 = '0; hist2 = '0; img = '0;
        cls_hist.delete();
        ref_held = 1'b0; ref_code = 4'h0;
      end else begin
        int mcol;
        mcol = (t / SD) % 4;
        if (t % SD == SD - 1) begin
          // row value seen now was on the pins two edges ago
          for (int r = 0; r < 4; r++) img[r*4+mcol] = hist2[r*4+mcol];
          if (mcol == 3) begin
            int n, k, cls;
            bit st;
            n = 0; k = 0;
            for (int r = 0; r < 4; r++)
              for (int c = 0; c < 4; c++)
                if (img[r*4+c]) begin n++; k = int'(key_of(r, c)); end
            cls = (n == 0) ? 16 : (n == 1) ? k : 17;
            cls_hist.push_back(cls);
            if (cls_hist.size() > DB) void'(cls_hist.pop_front());
            st = (cls != 17) && (cls_hist.size() == DB);
            foreach (cls_hist[i]) if (cls_hist[i] != cls) st = 1'b0;
            if (st) begin
              if (cls == 16) ref_held = 1'b0;
              else if (!ref_held || ref_code != 4'(cls)) begin
                exp_q.push_back(4'(cls));
                ref_held = 1'b1;
                ref_code = 4'(cls);
              end
            end
          end
        end
        hist2 = hist1;
        hist1 = pressed;
        t++;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------
  int pulse_cnt    = 0;
  int last_pulse_t = 0;

  initial begin
    @(posedge clk);
    forever begin
      logic [3:0] exp_col;
      logic       exp_pulse;
      logic [3:0] e;
      @(negedge clk);
      exp_col = ~(4'b0001 << ((t / SD) % 4));
      check("col_n", bus.col_n, exp_col);
      exp_pulse = (exp_q.size() > 0);
      check("key_valid", bus.key_valid, exp_pulse);
      if (bus.key_valid) begin
        pulse_cnt++;
        last_pulse_t = t;
      end
      if (exp_pulse) begin
        e = exp_q.pop_front();
        if (bus.key_valid) check("pulse_code", bus.key_code, e);
      end
      check("key_held", bus.key_held, ref_held);
      check("key_code", bus.key_code, ref_code);
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic align_scan();
    while (t % SCAN != 0) step();
  endtask

  task automatic wait_pulse(input int base, input int limit, input string name);
    int n;
    n = 0;
    while (pulse_cnt == base && n < limit) begin
      step();
      n++;
    end
    check(name, 32'(pulse_cnt > base), 32'd1);
  endtask

  initial begin
    logic [3:0] exp_rot [4];
    int p, t0;

    // 1. reset and scan rotation
    rst = 1'b1;
    repeat (3) step();
    check("rst_col_n", bus.col_n, 4'b1110);
    check("rst_key_code", bus.key_code, 4'h0);
    check("rst_key_valid", bus.key_valid, 1'b0);
    check("rst_key_held", bus.key_held, 1'b0);
    rst = 1'b0;
    exp_rot[0] = 4'b1101; exp_rot[1] = 4'b1011; exp_rot[2] = 4'b0111; exp_rot[3] = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      repeat (SD) step();
      check("rotate_col_n", bus.col_n, exp_rot[i]);
    end

    // 2. steady press of key 6
    align_scan();
    p = pulse_cnt;
    t0 = t;
    pressed = kbit(1, 2);
    wait_pulse(p, 200, "t2_pulse_seen");
    check("t2_code", bus.key_code, 4'h6);
    check("t2_held", bus.key_held, 1'b1);
    check("t2_latency_in_range",
          32'((last_pulse_t - t0) >= DB * SCAN && (last_pulse_t - t0) <= (DB + 1) * SCAN + 3), 32'd1);
    p = pulse_cnt;
    repeat (20 * SCAN) step();
    check("t2_no_retrigger", 32'(pulse_cnt - p), 32'd0);

    // 4. release, then roll-over D -> 1
    pressed = '0;
    repeat ((DB + 1) * SCAN) step();
    check("t4_released", bus.key_held, 1'b0);
    check("t4_code_kept", bus.key_code, 4'h6);
    p = pulse_cnt;
    pressed = kbit(3, 3);
    wait_pulse(p, 200, "t4_pulse_d");
    check("t4_code_d", bus.key_code, 4'hD);
    p = pulse_cnt;
    pressed = kbit(0, 0);
    wait_pulse(p, 200, "t4_pulse_1");
    check("t4_code_1", bus.key_code, 4'h1);
    check("t4_held_rollover", bus.key_held, 1'b1);

    // 5. multi-key: key 1 plus key 9
    p = pulse_cnt;
    pressed = kbit(0, 0) | kbit(2, 2);
    repeat (20 * SCAN) step();
    check("t5_no_pulse", 32'(pulse_cnt - p), 32'd0);
    check("t5_held", bus.key_held, 1'b1);
    check("t5_code", bus.key_code, 4'h1);
    pressed = '0;
    repeat (5 * SCAN) step();

    // 3. bounce on key 5, then settle
    align_scan();
    p = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      pressed = pressed ^ kbit(1, 1);
      repeat (20) step();
    end
    check("t3_no_pulse_bounce", 32'(pulse_cnt - p), 32'd0);
    pressed = kbit(1, 1);
    t0 = t;
    wait_pulse(p, 200, "t3_pulse_seen");
    check("t3_code", bus.key_code, 4'h5);
    check("t3_latency_max", 32'((last_pulse_t - t0) <= (DB + 1) * SCAN + 3), 32'd1);
    repeat (5 * SCAN) step();
    check("t3_single_pulse", 32'(pulse_cnt - p), 32'd1);
    pressed = '0;
    repeat (5 * SCAN) step();

    // 6. reset mid-debounce of key 8
    align_scan();
    p = pulse_cnt;
    pressed = kbit(2, 1);
    repeat (2 * SCAN) step();
    rst = 1'b1;
    repeat (3) step();
    check("t6_rst_col_n", bus.col_n, 4'b1110);
    check("t6_rst_code", bus.key_code, 4'h0);
    check("t6_rst_held", bus.key_held, 1'b0);
    check("t6_no_pulse_before", 32'(pulse_cnt - p), 32'd0);
    rst = 1'b0;
    wait_pulse(p, 200, "t6_pulse_seen");
    check("t6_code", bus.key_code, 4'h8);
    check("t6_full_rescan", 32'(last_pulse_t >= DB * SCAN), 32'd1);
    pressed = '0;
    repeat (5 * SCAN) step();

    // Randomized key activity, checked entirely by the scoreboard
    for (int i = 0; i < 25; i++) begin
      int sel, dur;
      logic [15:0] m;
      sel = $urandom_range(0, 9);
      if (sel < 3) m = '0;
      else if (sel < 8) m = 16'(1) << $urandom_range(0, 15);
      else m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        for (int b = 0; b < 6; b++) begin
          pressed = (b % 2 == 0) ? m : 16'h0;
          repeat ($urandom_range(3, 25)) step();
        end
      end
      pressed = m;
      dur = $urandom_range(20, 220);
      repeat (dur) step();
    end
    pressed = '0;
    repeat (6 * SCAN) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
